// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and occupancy constants for pipeline stage registers
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_HALF  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_HALF  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  function automatic logic [1:0] state_occ(input pipe_state_t st);
    case (st)
      PS_HALF: state_occ = OCC_HALF;
      PS_FULL: state_occ = OCC_FULL;
      default: state_occ = OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - generic valid/ready stage register with optional two-entry skid buffer
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  parameter int                 SKID      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              ls_valid,
  input  logic [DATA_W-1:0] ls_data,
  output logic              ts_ready,
  output logic              ts_valid,
  output logic [DATA_W-1:0] ts_data,
  input  logic              ns_ready,
  output logic [1:0]        occ
);

  pipe_state_t       st_q, st_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_xfer, out_xfer;

  // Registered ready in skid mode breaks the ns_ready -> ts_ready chain across stages.
  if (SKID != 0) begin : g_skid
    assign ts_ready = (st_q != PS_FULL);
  end else begin : g_noskid
    assign ts_ready = (st_q == PS_EMPTY) || (ns_ready && !stall);
  end

  assign ts_valid = (st_q != PS_EMPTY) && !stall;
  assign ts_data  = main_q;
  assign occ      = state_occ(st_q);
  assign in_xfer  = ls_valid && ts_ready;
  assign out_xfer = ts_valid && ns_ready;

  always_comb begin
    st_d   = st_q;
    main_d = main_q;
    skid_d = skid_q;
    case (st_q)
      PS_EMPTY: begin
        if (in_xfer) begin
          st_d   = PS_HALF;
          main_d = ls_data;
        end
      end
      PS_HALF: begin
        if (in_xfer && !out_xfer) begin
          st_d   = PS_FULL;
          skid_d = ls_data;
        end else if (out_xfer && !in_xfer) begin
          st_d = PS_EMPTY;
        end else if (in_xfer && out_xfer) begin
          main_d = ls_data;
        end
      end
      PS_FULL: begin
        if (out_xfer) begin
          st_d   = PS_HALF;
          main_d = skid_q;
        end
      end
      default: st_d = PS_EMPTY;
    endcase
  end

  // Flush shares the reset path so any same-cycle transfer is discarded.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      st_q   <= PS_EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      st_q   <= st_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

endmodule
